// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Default 640x480@60 raster timing constants and helpers that
//               derive axis totals and check that a total fits its counter.
//               No ports (package).
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int C_COUNT_W   = 10;

    localparam int C_H_VISIBLE = 640;
    localparam int C_H_FRONT   = 16;
    localparam int C_H_SYNC    = 96;
    localparam int C_H_BACK    = 48;

    localparam int C_V_VISIBLE = 480;
    localparam int C_V_FRONT   = 10;
    localparam int C_V_SYNC    = 2;
    localparam int C_V_BACK    = 33;

    // Total positions on one axis (pixels per line or lines per frame).
    function automatic int axis_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    // A counter of 'width' bits can hold every value 0..total-1.
    function automatic bit fits_counter(input int total, input int width);
        return longint'(total) <= (longint'(1) << width);
    endfunction

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/vga_axis_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_timing
// Description : One raster axis: wrap counter plus visible/sync decode of the
//               counter's next value, so the parent can register the decode
//               alongside the count.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               advance           - step the counter this cycle
//               count             - current (registered) count
//               count_next        - value count takes on the next edge
//               wrap              - advancing from TOTAL-1 to 0 this cycle
//               visible_next      - count_next lies in the visible region
//               sync_next         - sync level (POL when active) for count_next
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_timing
    import vga_timing_pkg::*;
#(
    parameter int COUNT_W = C_COUNT_W,
    parameter int VISIBLE = C_H_VISIBLE,
    parameter int FRONT   = C_H_FRONT,
    parameter int SYNC    = C_H_SYNC,
    parameter int BACK    = C_H_BACK,
    parameter bit POL     = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               advance,
    output logic [COUNT_W-1:0] count,
    output logic [COUNT_W-1:0] count_next,
    output logic               wrap,
    output logic               visible_next,
    output logic               sync_next
);

    localparam int C_TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);

    localparam logic [COUNT_W-1:0] C_LAST = COUNT_W'(C_TOTAL - 1);
    // Region bounds carry one extra bit: a sync region ending exactly at
    // 2**COUNT_W must not truncate to zero.
    localparam logic [COUNT_W:0] C_VIS_END  = (COUNT_W+1)'(VISIBLE);
    localparam logic [COUNT_W:0] C_SYNC_BEG = (COUNT_W+1)'(VISIBLE + FRONT);
    localparam logic [COUNT_W:0] C_SYNC_END = (COUNT_W+1)'(VISIBLE + FRONT + SYNC);

    if (!fits_counter(C_TOTAL, COUNT_W)) begin : g_total_too_wide
        $error("vga_axis_timing: axis total %0d exceeds 2**%0d", C_TOTAL, COUNT_W);
    end

    logic [COUNT_W-1:0] r_count;
    logic               w_at_last;
    logic [COUNT_W:0]   w_next_ext;
    logic               w_sync_active;

    assign w_at_last  = (r_count == C_LAST);
    assign wrap       = advance & w_at_last;
    assign count_next = !advance  ? r_count :
                        w_at_last ? '0      : r_count + COUNT_W'(1);

    assign w_next_ext    = {1'b0, count_next};
    assign visible_next  = (w_next_ext < C_VIS_END);
    assign w_sync_active = (w_next_ext >= C_SYNC_BEG) && (w_next_ext < C_SYNC_END);
    assign sync_next     = w_sync_active ? POL : ~POL;

    // Reset parks on the last position so the first advance lands on 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= C_LAST;
        end else begin
            r_count <= count_next;
        end
    end

    assign count = r_count;

endmodule : vga_axis_timing
`default_nettype wire

// File: rtl/vga_timing_generator.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_generator
// Description : Parametrised VGA raster timing generator. Horizontal and
//               vertical counters advance on pix_en; sync, blanking,
//               (down-scaled) coordinates and line/frame strobes are decoded
//               from the next counter values and registered with them.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               pix_en            - pixel tick, all state advances only on it
//               hCount, vCount    - raster counters
//               x_pixel, y_pixel  - visible coordinates >> SCALE_SHIFT, else 0
//               drawn_en          - inside the visible area
//               hsync, vsync      - sync outputs at programmed polarity
//               line_start        - high for one tick while hCount==0
//               frame_start       - high for one tick while at (0,0)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int COUNT_W     = C_COUNT_W,
    parameter int H_VISIBLE   = C_H_VISIBLE,
    parameter int H_FRONT     = C_H_FRONT,
    parameter int H_SYNC      = C_H_SYNC,
    parameter int H_BACK      = C_H_BACK,
    parameter int V_VISIBLE   = C_V_VISIBLE,
    parameter int V_FRONT     = C_V_FRONT,
    parameter int V_SYNC      = C_V_SYNC,
    parameter int V_BACK      = C_V_BACK,
    parameter bit H_SYNC_POL  = 1'b0,
    parameter bit V_SYNC_POL  = 1'b0,
    parameter int SCALE_SHIFT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    output logic [COUNT_W-1:0] hCount,
    output logic [COUNT_W-1:0] vCount,
    output logic [COUNT_W-1:0] x_pixel,
    output logic [COUNT_W-1:0] y_pixel,
    output logic               drawn_en,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start
);

    logic [COUNT_W-1:0] w_h_next;
    logic [COUNT_W-1:0] w_v_next;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic               w_h_vis;
    logic               w_v_vis;
    logic               w_h_sync;
    logic               w_v_sync;
    logic               w_drawn_next;

    vga_axis_timing #(
        .COUNT_W (COUNT_W),
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .POL     (H_SYNC_POL)
    ) u_h_axis (
        .clk          (clk),
        .rst          (rst),
        .advance      (pix_en),
        .count        (hCount),
        .count_next   (w_h_next),
        .wrap         (w_h_wrap),
        .visible_next (w_h_vis),
        .sync_next    (w_h_sync)
    );

    // The vertical axis steps once per completed line.
    vga_axis_timing #(
        .COUNT_W (COUNT_W),
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .POL     (V_SYNC_POL)
    ) u_v_axis (
        .clk          (clk),
        .rst          (rst),
        .advance      (w_h_wrap),
        .count        (vCount),
        .count_next   (w_v_next),
        .wrap         (w_v_wrap),
        .visible_next (w_v_vis),
        .sync_next    (w_v_sync)
    );

    assign w_drawn_next = w_h_vis & w_v_vis;

    logic [COUNT_W-1:0] r_x_pixel;
    logic [COUNT_W-1:0] r_y_pixel;
    logic               r_drawn_en;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_line_start;
    logic               r_frame_start;

    // Counters reach 0 only by wrapping (reset parks them on TOTAL-1), so the
    // wrap signals are exactly "next count is 0". A v wrap always coincides
    // with an h wrap, which makes it the start of frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_pixel     <= '0;
            r_y_pixel     <= '0;
            r_drawn_en    <= 1'b0;
            r_hsync       <= ~H_SYNC_POL;
            r_vsync       <= ~V_SYNC_POL;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (pix_en) begin
            r_x_pixel     <= w_drawn_next ? (w_h_next >> SCALE_SHIFT) : '0;
            r_y_pixel     <= w_drawn_next ? (w_v_next >> SCALE_SHIFT) : '0;
            r_drawn_en    <= w_drawn_next;
            r_hsync       <= w_h_sync;
            r_vsync       <= w_v_sync;
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_v_wrap;
        end
    end

    assign x_pixel     = r_x_pixel;
    assign y_pixel     = r_y_pixel;
    assign drawn_en    = r_drawn_en;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule : vga_timing_generator
`default_nettype wire

// File: tb/tb_vga_timing_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_generator
// Description : Self-checking bench for vga_timing_generator. Three instances
//               share stimulus: A = default 640x480, B = default horizontal
//               with a short frame, positive hsync and 1-bit down-scale,
//               C = short line with default vertical timing and down-scale.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_generator;

    localparam int N_DUT = 3;
    localparam int HV [N_DUT] = '{640, 640, 8};
    localparam int HF [N_DUT] = '{16, 16, 2};
    localparam int HS [N_DUT] = '{96, 96, 3};
    localparam int HB [N_DUT] = '{48, 48, 3};
    localparam int VV [N_DUT] = '{480, 4, 480};
    localparam int VF [N_DUT] = '{10, 1, 10};
    localparam int VS [N_DUT] = '{2, 1, 2};
    localparam int VB [N_DUT] = '{33, 1, 33};
    localparam int HP [N_DUT] = '{0, 1, 0};
    localparam int VP [N_DUT] = '{0, 0, 0};
    localparam int SH [N_DUT] = '{0, 1, 1};

    logic clk = 1'b0;
    logic rst;
    logic pix_en;

    logic [9:0] h_o [N_DUT];
    logic [9:0] v_o [N_DUT];
    logic [9:0] x_o [N_DUT];
    logic [9:0] y_o [N_DUT];
    logic       de_o [N_DUT];
    logic       hs_o [N_DUT];
    logic       vs_o [N_DUT];
    logic       ls_o [N_DUT];
    logic       fs_o [N_DUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        vga_timing_generator #(
            .COUNT_W     (10),
            .H_VISIBLE   (HV[g]), .H_FRONT (HF[g]), .H_SYNC (HS[g]), .H_BACK (HB[g]),
            .V_VISIBLE   (VV[g]), .V_FRONT (VF[g]), .V_SYNC (VS[g]), .V_BACK (VB[g]),
            .H_SYNC_POL  (HP[g] != 0),
            .V_SYNC_POL  (VP[g] != 0),
            .SCALE_SHIFT (SH[g])
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .pix_en      (pix_en),
            .hCount      (h_o[g]),
            .vCount      (v_o[g]),
            .x_pixel     (x_o[g]),
            .y_pixel     (y_o[g]),
            .drawn_en    (de_o[g]),
            .hsync       (hs_o[g]),
            .vsync       (vs_o[g]),
            .line_start  (ls_o[g]),
            .frame_start (fs_o[g])
        );
    end

    typedef struct {
        int h, v, x, y;
        bit de, hs, vs, ls, fs;
    } out_t;

    typedef struct {
        int   n;    // pix_en ticks since reset
        int   d;    // instance index
        out_t e;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   mh [N_DUT];
    int   mv [N_DUT];
    out_t sb [$];

    function automatic out_t mk(int h, int v, int x, int y,
                                bit de, bit hs, bit vs, bit ls, bit fs);
        out_t o;
        o.h = h; o.v = v; o.x = x; o.y = y;
        o.de = de; o.hs = hs; o.vs = vs; o.ls = ls; o.fs = fs;
        return o;
    endfunction

    function automatic vec_t vec(int n, int d, int h, int v, int x, int y,
                                 bit de, bit hs, bit vs, bit ls, bit fs);
        vec_t t;
        t.n = n; t.d = d;
        t.e = mk(h, v, x, y, de, hs, vs, ls, fs);
        return t;
    endfunction

    function automatic out_t dut_out(int d);
        return mk(int'(h_o[d]), int'(v_o[d]), int'(x_o[d]), int'(y_o[d]),
                  de_o[d], hs_o[d], vs_o[d], ls_o[d], fs_o[d]);
    endfunction

    // Reference model: counters per instance, outputs decoded straight from
    // the raster definition.
    task automatic model_step(int d, bit r, bit en);
        int ht = HV[d] + HF[d] + HS[d] + HB[d];
        int vt = VV[d] + VF[d] + VS[d] + VB[d];
        if (r) begin
            mh[d] = ht - 1;
            mv[d] = vt - 1;
        end else if (en) begin
            if (mh[d] == ht - 1) begin
                mh[d] = 0;
                mv[d] = (mv[d] == vt - 1) ? 0 : mv[d] + 1;
            end else begin
                mh[d] = mh[d] + 1;
            end
        end
    endtask

    function automatic out_t model_out(int d);
        out_t o;
        bit   de = (mh[d] < HV[d]) && (mv[d] < VV[d]);
        bit   ha = (mh[d] >= HV[d] + HF[d]) && (mh[d] < HV[d] + HF[d] + HS[d]);
        bit   va = (mv[d] >= VV[d] + VF[d]) && (mv[d] < VV[d] + VF[d] + VS[d]);
        o.h  = mh[d];
        o.v  = mv[d];
        o.de = de;
        o.x  = de ? (mh[d] >> SH[d]) : 0;
        o.y  = de ? (mv[d] >> SH[d]) : 0;
        o.hs = ha ? (HP[d] != 0) : (HP[d] == 0);
        o.vs = va ? (VP[d] != 0) : (VP[d] == 0);
        o.ls = (mh[d] == 0);
        o.fs = (mh[d] == 0) && (mv[d] == 0);
        return o;
    endfunction

    task automatic check(string name, int d, out_t got, out_t exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got h=%0d v=%0d x=%0d y=%0d de=%0b hs=%0b vs=%0b ls=%0b fs=%0b, expected h=%0d v=%0d x=%0d y=%0d de=%0b hs=%0b vs=%0b ls=%0b fs=%0b (t=%0t)",
                     name, d, got.h, got.v, got.x, got.y, got.de, got.hs, got.vs, got.ls, got.fs,
                     exp.h, exp.v, exp.x, exp.y, exp.de, exp.hs, exp.vs, exp.ls, exp.fs, $time);
        end
    endtask

    task automatic check_int(string name, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // One clock: drive inputs, queue the model's prediction, then compare it
    // with what the DUTs present after the edge.
    task automatic step(bit r, bit en);
        out_t e;
        rst    = r;
        pix_en = en;
        for (int d = 0; d < N_DUT; d++) begin
            model_step(d, r, en);
            sb.push_back(model_out(d));
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < N_DUT; d++) begin
            e = sb.pop_front();
            check("scoreboard", d, dut_out(d), e);
        end
    endtask

    vec_t tbl [$];

    initial begin
        int ticks;
        int ls_cnt;
        int fs_cnt;

        rst    = 1'b1;
        pix_en = 1'b0;

        // Boundary vectors, ordered by tick count after reset.
        //             n     d  h    v    x    y    de hs vs ls fs
        tbl.push_back(vec(0,    0, 799, 524, 0,   0,   0, 1, 1, 0, 0));
        tbl.push_back(vec(0,    1, 799, 6,   0,   0,   0, 0, 1, 0, 0));
        tbl.push_back(vec(0,    2, 15,  524, 0,   0,   0, 1, 1, 0, 0));
        tbl.push_back(vec(1,    0, 0,   0,   0,   0,   1, 1, 1, 1, 1));
        tbl.push_back(vec(1,    2, 0,   0,   0,   0,   1, 1, 1, 1, 1));
        tbl.push_back(vec(8,    2, 7,   0,   3,   0,   1, 1, 1, 0, 0));
        tbl.push_back(vec(11,   2, 10,  0,   0,   0,   0, 0, 1, 0, 0));
        tbl.push_back(vec(14,   2, 13,  0,   0,   0,   0, 1, 1, 0, 0));
        tbl.push_back(vec(640,  0, 639, 0,   639, 0,   1, 1, 1, 0, 0));
        tbl.push_back(vec(640,  1, 639, 0,   319, 0,   1, 0, 1, 0, 0));
        tbl.push_back(vec(641,  0, 640, 0,   0,   0,   0, 1, 1, 0, 0));
        tbl.push_back(vec(656,  0, 655, 0,   0,   0,   0, 1, 1, 0, 0));
        tbl.push_back(vec(657,  0, 656, 0,   0,   0,   0, 0, 1, 0, 0));
        tbl.push_back(vec(657,  1, 656, 0,   0,   0,   0, 1, 1, 0, 0));
        tbl.push_back(vec(752,  0, 751, 0,   0,   0,   0, 0, 1, 0, 0));
        tbl.push_back(vec(753,  0, 752, 0,   0,   0,   0, 1, 1, 0, 0));
        tbl.push_back(vec(800,  0, 799, 0,   0,   0,   0, 1, 1, 0, 0));
        tbl.push_back(vec(801,  0, 0,   1,   0,   1,   1, 1, 1, 1, 0));
        tbl.push_back(vec(801,  1, 0,   1,   0,   0,   1, 0, 1, 1, 0));
        tbl.push_back(vec(3201, 1, 0,   4,   0,   0,   0, 0, 1, 1, 0));
        tbl.push_back(vec(4001, 1, 0,   5,   0,   0,   0, 0, 0, 1, 0));
        tbl.push_back(vec(4801, 1, 0,   6,   0,   0,   0, 0, 1, 1, 0));
        tbl.push_back(vec(5601, 1, 0,   0,   0,   0,   1, 0, 1, 1, 1));
        tbl.push_back(vec(7672, 2, 7,   479, 3,   239, 1, 1, 1, 0, 0));
        tbl.push_back(vec(7673, 2, 8,   479, 0,   0,   0, 1, 1, 0, 0));
        tbl.push_back(vec(7840, 2, 15,  489, 0,   0,   0, 1, 1, 0, 0));
        tbl.push_back(vec(7841, 2, 0,   490, 0,   0,   0, 1, 0, 1, 0));
        tbl.push_back(vec(7872, 2, 15,  491, 0,   0,   0, 1, 0, 0, 0));
        tbl.push_back(vec(7873, 2, 0,   492, 0,   0,   0, 1, 1, 1, 0));
        tbl.push_back(vec(8400, 2, 15,  524, 0,   0,   0, 1, 1, 0, 0));
        tbl.push_back(vec(8401, 2, 0,   0,   0,   0,   1, 1, 1, 1, 1));

        // Reset, then free-running pix_en through the table.
        repeat (3) step(1'b1, 1'b0);
        ticks = 0;
        foreach (tbl[i]) begin
            while (ticks < tbl[i].n) begin
                step(1'b0, 1'b1);
                ticks++;
            end
            check($sformatf("vector%0d_n%0d", i, tbl[i].n), tbl[i].d,
                  dut_out(tbl[i].d), tbl[i].e);
        end

        // pix_en one clock in four: strobes must hold for the full period.
        step(1'b1, 1'b0);
        ls_cnt = 0;
        fs_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, (i % 4) == 0);
            if (ls_o[0]) ls_cnt++;
            if (fs_o[0]) fs_cnt++;
        end
        check_int("gated_line_start_clks", ls_cnt, 4);
        check_int("gated_frame_start_clks", fs_cnt, 4);
        check_int("gated_hcount", int'(h_o[0]), 3);

        // Mid-frame reset: rst wins over a simultaneous pix_en.
        step(1'b1, 1'b0);
        repeat (2 * 800 + 301) step(1'b0, 1'b1);
        check("midframe_position", 0, dut_out(0), mk(300, 2, 300, 2, 1, 1, 1, 0, 0));
        step(1'b1, 1'b1);
        check("midframe_reset", 0, dut_out(0), mk(799, 524, 0, 0, 0, 1, 1, 0, 0));
        step(1'b0, 1'b1);
        check("after_reset_tick", 0, dut_out(0), mk(0, 0, 0, 0, 1, 1, 1, 1, 1));
        repeat (4) step(1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_vga_timing_generator
`default_nettype wire
